// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with valid/ready on input and every output.
// Each channel is a one-entry register; broadcast loads all channels atomically.

module dmux_chan #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  // data only changes on load, so it holds while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module dmux_stream #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_cnt
);
  typedef struct packed {
    logic             bcast;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } req_t;

  req_t                req;
  logic [CHANNELS-1:0] tgt;
  logic [CHANNELS-1:0] free;
  logic                xfer;
  logic                drop;

  assign req = '{bcast: in_bcast, sel: in_sel, data: in_data};

  // An out-of-range select matches no channel, leaving the target set empty.
  assign free     = ~out_valid | out_ready;
  assign in_ready = &(free | ~tgt);
  assign xfer     = in_valid & in_ready;
  assign drop     = xfer & ~(|tgt);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign tgt[k] = req.bcast | (req.sel == SEL_W'(k));

    dmux_chan #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .reset (reset),
      .load  (xfer & tgt[k]),
      .din   (req.data),
      .ready (out_ready[k]),
      .data  (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
endmodule
